// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: LSB-first through one full-adder cell with a registered carry.
// Operands in and results out each go over a valid/ready handshake; one operation in flight.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SH_W = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;

    logic [WIDTH-1:0]  r_sh_a;
    logic [WIDTH-1:0]  r_sh_b;
    logic [SH_W-1:0]   r_sh_s;
    logic              r_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_out_hs;
    logic              w_last;
    logic              w_bit_s;
    logic              w_bit_c;
    logic [WIDTH-1:0]  w_sum_cat;

    assign w_accept  = in_valid & r_in_ready & (r_state == ST_IDLE);
    assign w_out_hs  = r_out_valid & out_ready;
    assign w_last    = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Single full-adder cell on the current LSBs.
    assign w_bit_s   = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
    assign w_bit_c   = (r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_carry) | (r_sh_b[0] & r_carry);
    // New bit enters at the MSB; on the last edge this is the complete sum.
    assign w_sum_cat = {w_bit_s, r_sh_s};

    // State register; handshake flags are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state logic; any unknown encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (w_out_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags are valid in that state.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: w_in_ready_nxt  = 1'b1;
            ST_DONE: w_out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_s  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_carry <= cin;
                        r_sh_s  <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_sh_s  <= w_sum_cat[WIDTH-1:1];
                    r_carry <= w_bit_c;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_sum  <= w_sum_cat;
                        r_cout <= w_bit_c;
                        r_ovf  <= r_carry ^ w_bit_c;
                    end else begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH = 2, 8 and 16.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [2:0]  ovl;
    logic [2:0]  co;
    logic [2:0]  of;
    logic        ordy;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        tcin;
    logic [1:0]  s2;
    logic [7:0]  s8;
    logic [15:0] s16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(opa[1:0]), .b(opb[1:0]), .cin(tcin),
        .out_valid(ovl[0]), .out_ready(ordy), .sum(s2), .cout(co[0]), .ovf(of[0]));

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(opa[7:0]), .b(opb[7:0]), .cin(tcin),
        .out_valid(ovl[1]), .out_ready(ordy), .sum(s8), .cout(co[1]), .ovf(of[1]));

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(opa[15:0]), .b(opb[15:0]), .cin(tcin),
        .out_valid(ovl[2]), .out_ready(ordy), .sum(s16), .cout(co[2]), .ovf(of[2]));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rd_sum(input int k);
        case (k)
            0:       return 64'(s2);
            1:       return 64'(s8);
            default: return 64'(s16);
        endcase
    endfunction

    // Reference: wide add, carry is bit w, overflow from operand/result signs.
    function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic c);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] s;
        logic        cy;
        logic        ov;
        mask = (65'(1) << w) - 65'(1);
        full = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + 65'(c);
        s    = 64'(full & mask);
        cy   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return {ov, cy, s};
    endfunction

    // Present operands, wait for acceptance, then wait for out_valid (no handshake).
    task automatic do_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                         input logic c, output logic [63:0] s, output logic co_o,
                         output logic of_o, output int lat, output int acc_cyc,
                         output bit busy_ok);
        int n;
        opa  = av;
        opb  = bv;
        tcin = c;
        iv[k] = 1'b1;
        n = 0;
        while (!ir[k] && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(ir[k]), 64'd1);
        acc_cyc = cyc;
        tick();
        iv[k] = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        while (!ovl[k] && lat < 200) begin
            if (ir[k]) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk("out_valid_wait", 64'(ovl[k]), 64'd1);
        if (ir[k]) busy_ok = 1'b0;
        s    = rd_sum(k);
        co_o = co[k];
        of_o = of[k];
    endtask

    initial begin
        logic [63:0] s;
        logic        cy;
        logic        ov;
        logic [65:0] e;
        logic [63:0] av;
        logic [63:0] bv;
        logic        cv;
        int          lat;
        int          acc;
        int          prev;
        int          w;
        int          n;
        bit          busy_ok;
        bit          pulse;

        vecs[0] = '{8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        rst  = 1'b1;
        iv   = 3'b000;
        ordy = 1'b1;
        opa  = '0;
        opb  = '0;
        tcin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready",  64'(ir[1]),  64'd1);
        chk("rst_out_valid", 64'(ovl[1]), 64'd0);
        chk("rst_sum",       64'(s8),     64'd0);
        chk("rst_cout_ovf",  64'({co[1], of[1]}), 64'd0);

        // Table vectors at WIDTH=8, out_ready high.
        for (int i = 0; i < 7; i++) begin
            do_op(1, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, s, cy, ov, lat, acc, busy_ok);
            chk("vec_latency",  64'(lat), 64'd8);
            chk("vec_busy",     64'(busy_ok), 64'd1);
            chk("vec_sum",      s, 64'(vecs[i].s));
            chk("vec_cout",     64'(cy), 64'(vecs[i].co));
            chk("vec_ovf",      64'(ov), 64'(vecs[i].ov));
            tick();
            chk("vec_hs_valid", 64'(ovl[1]), 64'd0);
            chk("vec_hs_ready", 64'(ir[1]),  64'd1);
        end

        // Backpressure: result held stable for 5 cycles.
        ordy = 1'b0;
        do_op(1, 64'h7F, 64'h01, 1'b0, s, cy, ov, lat, acc, busy_ok);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(ovl[1]), 64'd1);
            chk("bp_hold",  64'({of[1], co[1], s8}), 64'h280);
        end
        ordy = 1'b1;
        tick();
        chk("bp_release_valid", 64'(ovl[1]), 64'd0);
        chk("bp_release_ready", 64'(ir[1]),  64'd1);

        // New operands offered while busy must wait for in_ready.
        opa = 64'h01;
        opb = 64'h02;
        tcin = 1'b0;
        iv[1] = 1'b1;
        tick();
        opa = 64'hAA;
        opb = 64'h55;
        busy_ok = 1'b1;
        n = 0;
        while (!ovl[1] && n < 50) begin
            if (ir[1]) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk("busy_first_sum", 64'(s8), 64'h03);
        chk("busy_ready_low", 64'(busy_ok), 64'd1);
        tick();
        chk("busy_ready_back", 64'(ir[1]), 64'd1);
        do_op(1, 64'hAA, 64'h55, 1'b0, s, cy, ov, lat, acc, busy_ok);
        chk("busy_second_sum", s, 64'hFF);
        tick();

        // Reset in the 4th RUN cycle discards the operation.
        opa = 64'hFF;
        opb = 64'hFF;
        tcin = 1'b1;
        iv[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready",  64'(ir[1]),  64'd1);
        chk("midrst_out_valid", 64'(ovl[1]), 64'd0);
        chk("midrst_result",    64'({of[1], co[1], s8}), 64'd0);
        pulse = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ovl[1]) pulse = 1'b1;
            tick();
        end
        chk("midrst_no_pulse", 64'(pulse), 64'd0);
        do_op(1, 64'h10, 64'h20, 1'b0, s, cy, ov, lat, acc, busy_ok);
        chk("midrst_next_sum", s, 64'h30);
        tick();

        // Back-to-back random operations per width, out_ready tied high.
        for (int k = 0; k < 3; k++) begin
            w = (k == 0) ? 2 : ((k == 1) ? 8 : 16);
            prev = 0;
            for (int i = 0; i < 200; i++) begin
                av = {$urandom(), $urandom()} & ((64'd1 << w) - 64'd1);
                bv = {$urandom(), $urandom()} & ((64'd1 << w) - 64'd1);
                cv = 1'($urandom_range(1, 0));
                e  = model(w, av, bv, cv);
                do_op(k, av, bv, cv, s, cy, ov, lat, acc, busy_ok);
                chk("rnd_sum",  s, e[63:0]);
                chk("rnd_cout", 64'(cy), 64'(e[64]));
                chk("rnd_ovf",  64'(ov), 64'(e[65]));
                chk("rnd_busy", 64'(busy_ok), 64'd1);
                if (i > 0) chk("rnd_spacing", 64'(acc - prev), 64'(w + 2));
                prev = acc;
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
